// File: rtl/TauCfg.sv
// Shared configuration for the SRAM-to-DRAM scatter path: default sizes, derived
// lane-offset widths and the one-hot FSM state encoding.
package TauCfg;

  localparam int unsigned LOCAL_ADDR_BW0 = 8;
  localparam int unsigned GLOBAL_ADDR_BW = 12;
  localparam int unsigned DATA_BW        = 8;
  localparam int unsigned VECTOR_SIZE    = 4;
  localparam int unsigned CACHE_SIZE     = 4;
  localparam int unsigned N_ICFG         = 4;

  localparam int unsigned CV_BW  = $clog2(VECTOR_SIZE);
  localparam int unsigned CC_BW  = $clog2(CACHE_SIZE);
  // Wide enough to hold VECTOR_SIZE, CACHE_SIZE and any chunk length.
  localparam int unsigned CV_BW1 = ((CV_BW > CC_BW) ? CV_BW : CC_BW) + 1;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    RDREQ  = 5'b00010,
    RDWAIT = 5'b00100,
    SEND   = 5'b01000,
    DONE   = 5'b10000
  } srs_state_e;

endpackage

// File: rtl/sram_read_scatter_align.sv
// Two-stage lane aligner: moves a chunk from its SRAM lane offset to its DRAM lane
// offset and builds the matching write mask; lanes outside the mask are zeroed.
module sram_read_scatter_align #(
  parameter int unsigned DBW    = TauCfg::DATA_BW,
  parameter int unsigned VSIZE  = TauCfg::VECTOR_SIZE,
  parameter int unsigned CSIZE  = TauCfg::CACHE_SIZE,
  parameter int unsigned CV_BW  = TauCfg::CV_BW,
  parameter int unsigned CC_BW  = TauCfg::CC_BW,
  parameter int unsigned CV_BW1 = TauCfg::CV_BW1
) (
  input  logic [VSIZE*DBW-1:0] i_vec,
  input  logic [CV_BW-1:0]     i_loff,
  input  logic [CC_BW-1:0]     i_goff,
  input  logic [CV_BW1-1:0]    i_adv,
  output logic [CSIZE*DBW-1:0] o_data,
  output logic [CSIZE-1:0]     o_mask
);

  localparam int unsigned WW = ((VSIZE > CSIZE) ? VSIZE : CSIZE) * DBW;

  logic [WW-1:0]    w_shr;
  logic [WW-1:0]    w_shl;
  logic [CSIZE-1:0] w_mask;

  always_comb begin
    w_shr  = WW'(i_vec) >> (i_loff * DBW);
    w_shl  = w_shr << (i_goff * DBW);
    w_mask = (~({CSIZE{1'b1}} << i_adv)) << i_goff;
    o_data = '0;
    for (int i = 0; i < CSIZE; i++) begin
      o_data[i*DBW +: DBW] = w_shl[i*DBW +: DBW] & {DBW{w_mask[i]}};
    end
    o_mask = w_mask;
  end

endmodule

// File: rtl/sram_read_scatter.sv
// Copies a linear run of SRAM words to an arbitrary DRAM word address as masked line beats.
// Define SRAM_READ_SCATTER_MERGE_EN to OR-merge partial-line chunks into a single beat.
module sram_read_scatter #(
  parameter int unsigned LBW    = TauCfg::LOCAL_ADDR_BW0,
  parameter int unsigned GBW    = TauCfg::GLOBAL_ADDR_BW,
  parameter int unsigned DBW    = TauCfg::DATA_BW,
  parameter int unsigned VSIZE  = TauCfg::VECTOR_SIZE,
  parameter int unsigned CSIZE  = TauCfg::CACHE_SIZE,
  parameter int unsigned N_ICFG = TauCfg::N_ICFG,
  localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               alloc_rdy,
  output logic                               alloc_ack,
  input  logic [LBW-1:0]                     i_linear,
  input  logic [GBW-1:0]                     i_global,
  input  logic [LBW:0]                       i_len,
  input  logic [ICFG_BW-1:0]                 i_id,
  output logic                               sramrd_rdy,
  input  logic                               sramrd_ack,
  output logic [ICFG_BW-1:0]                 o_sramrd_id,
  output logic [LBW-TauCfg::CV_BW-1:0]       o_sramrd_hiaddr,
  input  logic                               sramrd_dval,
  input  logic [VSIZE*DBW-1:0]               i_sramrd_data,
  output logic                               dramw_rdy,
  input  logic                               dramw_ack,
  output logic [GBW-TauCfg::CC_BW-1:0]       o_dramw_addr,
  output logic [CSIZE*DBW-1:0]               o_dramw_data,
  output logic [CSIZE-1:0]                   o_dramw_mask,
  output logic                               done_rdy,
  input  logic                               done_ack,
  output logic [ICFG_BW-1:0]                 o_done_id
);

  localparam int unsigned CV_BW  = TauCfg::CV_BW;
  localparam int unsigned CC_BW  = TauCfg::CC_BW;
  localparam int unsigned CV_BW1 = TauCfg::CV_BW1;

  TauCfg::srs_state_e r_state, w_state_nxt;

  logic [LBW-1:0]       r_lptr;
  logic [GBW-1:0]       r_gptr;
  logic [LBW:0]         r_left;
  logic [ICFG_BW-1:0]   r_id;
  logic [VSIZE*DBW-1:0] r_vbuf;

  logic [CV_BW-1:0]     w_loff;
  logic [CC_BW-1:0]     w_goff;
  logic [CV_BW1-1:0]    w_vrem, w_crem, w_lrem, w_adv;
  logic [LBW:0]         w_left_nxt;
  logic                 w_vec_done, w_emit, w_step;
  logic                 w_alloc_ack, w_sramrd_rdy, w_dramw_rdy, w_done_rdy;
  logic [CSIZE*DBW-1:0] w_chunk_data, w_beat_data;
  logic [CSIZE-1:0]     w_chunk_mask, w_beat_mask;

  assign w_loff = r_lptr[CV_BW-1:0];
  assign w_goff = r_gptr[CC_BW-1:0];
  assign w_vrem = CV_BW1'(VSIZE) - CV_BW1'(w_loff);
  assign w_crem = CV_BW1'(CSIZE) - CV_BW1'(w_goff);
  assign w_lrem = (r_left >= (LBW+1)'(VSIZE)) ? CV_BW1'(VSIZE) : CV_BW1'(r_left);

  always_comb begin
    w_adv = w_lrem;
    if (w_vrem < w_adv) w_adv = w_vrem;
    if (w_crem < w_adv) w_adv = w_crem;
  end

  assign w_left_nxt = r_left - (LBW+1)'(w_adv);
  assign w_vec_done = (CV_BW1'(w_loff) + w_adv) == CV_BW1'(VSIZE);

  sram_read_scatter_align #(
    .DBW   (DBW),
    .VSIZE (VSIZE),
    .CSIZE (CSIZE),
    .CV_BW (CV_BW),
    .CC_BW (CC_BW),
    .CV_BW1(CV_BW1)
  ) u_align (
    .i_vec (r_vbuf),
    .i_loff(w_loff),
    .i_goff(w_goff),
    .i_adv (w_adv),
    .o_data(w_chunk_data),
    .o_mask(w_chunk_mask)
  );

`ifdef SRAM_READ_SCATTER_MERGE_EN
  logic [CSIZE*DBW-1:0] r_line_data;
  logic [CSIZE-1:0]     r_line_mask;
  logic                 w_line_done, w_merge;

  assign w_line_done = (CV_BW1'(w_goff) + w_adv) == CV_BW1'(CSIZE);
  assign w_emit      = w_line_done || (w_left_nxt == '0);
  assign w_merge     = (r_state == TauCfg::SEND) && !w_emit;
  assign w_beat_data = r_line_data | w_chunk_data;
  assign w_beat_mask = r_line_mask | w_chunk_mask;

  // Cleared on every emitted beat, so a new line always starts empty.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_line_data <= '0;
      r_line_mask <= '0;
    end else if (w_merge) begin
      r_line_data <= w_beat_data;
      r_line_mask <= w_beat_mask;
    end else if (w_step) begin
      r_line_data <= '0;
      r_line_mask <= '0;
    end
  end
`else
  assign w_emit      = 1'b1;
  assign w_beat_data = w_chunk_data;
  assign w_beat_mask = w_chunk_mask;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_alloc_ack  = 1'b0;
    w_sramrd_rdy = 1'b0;
    w_dramw_rdy  = 1'b0;
    w_done_rdy   = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      TauCfg::IDLE: begin
        if (alloc_rdy) begin
          w_alloc_ack = 1'b1;
          w_state_nxt = (i_len == '0) ? TauCfg::DONE : TauCfg::RDREQ;
        end
      end
      TauCfg::RDREQ: begin
        w_sramrd_rdy = 1'b1;
        if (sramrd_ack) w_state_nxt = TauCfg::RDWAIT;
      end
      TauCfg::RDWAIT: begin
        if (sramrd_dval) w_state_nxt = TauCfg::SEND;
      end
      TauCfg::SEND: begin
        if (w_emit) begin
          w_dramw_rdy = 1'b1;
          if (dramw_ack) begin
            w_step = 1'b1;
            if (w_left_nxt == '0)  w_state_nxt = TauCfg::DONE;
            else if (w_vec_done)   w_state_nxt = TauCfg::RDREQ;
            else                   w_state_nxt = TauCfg::SEND;
          end
        end else begin
          // Partial line folded into the line buffer; fetch the next vector.
          w_step      = 1'b1;
          w_state_nxt = TauCfg::RDREQ;
        end
      end
      TauCfg::DONE: begin
        w_done_rdy = 1'b1;
        if (done_ack) w_state_nxt = TauCfg::IDLE;
      end
      default: w_state_nxt = TauCfg::IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= TauCfg::IDLE;
      r_lptr  <= '0;
      r_gptr  <= '0;
      r_left  <= '0;
      r_id    <= '0;
      r_vbuf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_alloc_ack) begin
        r_lptr <= i_linear;
        r_gptr <= i_global;
        r_left <= i_len;
        r_id   <= i_id;
      end
      if (w_step) begin
        r_lptr <= r_lptr + LBW'(w_adv);
        r_gptr <= r_gptr + GBW'(w_adv);
        r_left <= w_left_nxt;
      end
      if ((r_state == TauCfg::RDWAIT) && sramrd_dval) r_vbuf <= i_sramrd_data;
    end
  end

  // Payloads are zero whenever their handshake is idle.
  assign alloc_ack       = w_alloc_ack & i_rst;
  assign sramrd_rdy      = w_sramrd_rdy;
  assign o_sramrd_id     = w_sramrd_rdy ? r_id : '0;
  assign o_sramrd_hiaddr = w_sramrd_rdy ? r_lptr[LBW-1:CV_BW] : '0;
  assign dramw_rdy       = w_dramw_rdy;
  assign o_dramw_addr    = w_dramw_rdy ? r_gptr[GBW-1:CC_BW] : '0;
  assign o_dramw_data    = w_dramw_rdy ? w_beat_data : '0;
  assign o_dramw_mask    = w_dramw_rdy ? w_beat_mask : '0;
  assign done_rdy        = w_done_rdy;
  assign o_done_id       = w_done_rdy ? r_id : '0;

endmodule

// File: tb/tb_sram_read_scatter.sv
// Randomised and directed bench for sram_read_scatter with VSIZE=CSIZE=4, DBW=8; the
// expected DRAM image and beat/read counts come from a word-level copy model.
module tb_sram_read_scatter;

  localparam int unsigned LBW = 8, GBW = 12, DBW = 8, VSIZE = 4, CSIZE = 4, NIC = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        alloc_rdy = 1'b0, alloc_ack;
  logic [7:0]  i_linear = '0;
  logic [11:0] i_global = '0;
  logic [8:0]  i_len = '0;
  logic [2:0]  i_id = '0;
  logic        sramrd_rdy, sramrd_ack, sramrd_dval;
  logic [2:0]  o_sramrd_id;
  logic [5:0]  o_sramrd_hiaddr;
  logic [31:0] i_sramrd_data;
  logic        dramw_rdy, dramw_ack;
  logic [9:0]  o_dramw_addr;
  logic [31:0] o_dramw_data;
  logic [3:0]  o_dramw_mask;
  logic        done_rdy, done_ack;
  logic [2:0]  o_done_id;

  sram_read_scatter #(
    .LBW(LBW), .GBW(GBW), .DBW(DBW), .VSIZE(VSIZE), .CSIZE(CSIZE), .N_ICFG(NIC)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .alloc_rdy(alloc_rdy), .alloc_ack(alloc_ack), .i_linear(i_linear), .i_global(i_global),
    .i_len(i_len), .i_id(i_id),
    .sramrd_rdy(sramrd_rdy), .sramrd_ack(sramrd_ack), .o_sramrd_id(o_sramrd_id),
    .o_sramrd_hiaddr(o_sramrd_hiaddr), .sramrd_dval(sramrd_dval), .i_sramrd_data(i_sramrd_data),
    .dramw_rdy(dramw_rdy), .dramw_ack(dramw_ack), .o_dramw_addr(o_dramw_addr),
    .o_dramw_data(o_dramw_data), .o_dramw_mask(o_dramw_mask),
    .done_rdy(done_rdy), .done_ack(done_ack), .o_done_id(o_done_id)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } beat_t;

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  sram [256];
  logic [7:0]  dram [4096];
  bit          wr   [4096];
  int          s_lat_min = 1, s_lat_max = 3, ack_pct = 60, s_lat_cnt = 0;
  bit          d_hold = 1'b0;
  logic [5:0]  s_pend;
  logic [8:0]  rd_q[$];
  beat_t       beat_q[$];
  logic [2:0]  done_q[$];

`ifdef SRAM_READ_SCATTER_MERGE_EN
  localparam bit MergeEn = 1'b1;
`else
  localparam bit MergeEn = 1'b0;
`endif

  function automatic logic [31:0] vec_of(input logic [5:0] hi);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = sram[int'(hi) * 4 + i];
    return v;
  endfunction

  function automatic logic [29:0] ctl_outs();
    return {alloc_ack, sramrd_rdy, o_sramrd_id, o_sramrd_hiaddr, dramw_rdy, o_dramw_addr,
            o_dramw_mask, done_rdy, o_done_id};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM responder: random ack, read data returned a few cycles after the transfer.
  initial begin
    bit fire;
    logic [8:0] a;
    sramrd_ack = 1'b0; sramrd_dval = 1'b0; i_sramrd_data = '0;
    forever begin
      @(negedge i_clk);
      fire = sramrd_rdy && sramrd_ack && i_rst;
      a    = {o_sramrd_id, o_sramrd_hiaddr};
      @(posedge i_clk); #1;
      sramrd_dval = 1'b0;
      if (s_lat_cnt > 0) begin
        s_lat_cnt--;
        if (s_lat_cnt == 0) begin
          sramrd_dval   = 1'b1;
          i_sramrd_data = vec_of(s_pend);
        end
      end
      if (fire) begin
        rd_q.push_back(a);
        s_pend    = a[5:0];
        s_lat_cnt = $urandom_range(s_lat_max, s_lat_min);
      end
      sramrd_ack = ($urandom_range(99, 0) < ack_pct);
    end
  end

  initial begin
    bit fire;
    beat_t b;
    dramw_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      fire   = dramw_rdy && dramw_ack && i_rst;
      b.addr = o_dramw_addr; b.data = o_dramw_data; b.mask = o_dramw_mask;
      @(posedge i_clk); #1;
      if (fire) beat_q.push_back(b);
      dramw_ack = !d_hold && ($urandom_range(99, 0) < ack_pct);
    end
  end

  initial begin
    bit fire;
    logic [2:0] id;
    done_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      fire = done_rdy && done_ack && i_rst;
      id   = o_done_id;
      @(posedge i_clk); #1;
      if (fire) done_q.push_back(id);
      done_ack = ($urandom_range(99, 0) < ack_pct);
    end
  end

  task automatic start_job(input logic [7:0] lin, input logic [11:0] glob, input logic [8:0] len,
                           input logic [2:0] id);
    int t = 0;
    @(posedge i_clk); #1;
    alloc_rdy = 1'b1; i_linear = lin; i_global = glob; i_len = len; i_id = id;
    do begin
      @(negedge i_clk);
      t++;
    end while (!alloc_ack && t < 100);
    chk("alloc_ack", alloc_ack, 1);
    @(posedge i_clk); #1;
    alloc_rdy = 1'b0; i_linear = $urandom; i_global = $urandom; i_len = $urandom; i_id = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_q.size() == 0 && t < 3000) begin
      @(negedge i_clk);
      t++;
    end
    chk("done_seen", done_q.size() != 0, 1);
  endtask

  // Word-level model: word k of the run goes from sram[lin+k] to dram[glob+k].
  task automatic check_job(input logic [7:0] lin, input logic [11:0] glob, input int len,
                           input logic [2:0] id);
    int exp_beats = 0, exp_reads = 0, bad = 0, a, off;
    for (int k = 0; k < len; k++) begin
      if (k == 0 || (lin + k) % 4 == 0) exp_reads++;
      if (k == 0 || (glob + k) % 4 == 0 || (!MergeEn && (lin + k) % 4 == 0)) exp_beats++;
    end
    chk("read_count", rd_q.size(), exp_reads);
    foreach (rd_q[i]) if (rd_q[i][8:6] !== id) bad++;
    chk("read_id", bad, 0);
    chk("beat_count", beat_q.size(), exp_beats);
    for (int i = 0; i < 4096; i++) wr[i] = 1'b0;
    bad = 0;
    foreach (beat_q[i]) begin
      for (int l = 0; l < 4; l++) begin
        a = int'(beat_q[i].addr) * 4 + l;
        if (beat_q[i].mask[l]) begin
          off = (a - int'(glob) + 4096) % 4096;
          if (off >= len || wr[a]) bad++;
          else begin
            wr[a]   = 1'b1;
            dram[a] = beat_q[i].data[l*8 +: 8];
          end
        end else if (beat_q[i].data[l*8 +: 8] !== 8'h00) bad++;
      end
    end
    chk("lane_rules", bad, 0);
    bad = 0;
    for (int k = 0; k < len; k++) begin
      a = (int'(glob) + k) % 4096;
      if (!wr[a] || dram[a] !== sram[(int'(lin) + k) % 256]) bad++;
    end
    chk("dram_image", bad, 0);
    chk("done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_id", done_q[0], id);
    rd_q.delete(); beat_q.delete(); done_q.delete();
  endtask

  task automatic run_job(input logic [7:0] lin, input logic [11:0] glob, input int len,
                         input logic [2:0] id);
    start_job(lin, glob, 9'(len), id);
    wait_done();
    check_job(lin, glob, len, id);
  endtask

  initial begin
    logic [3:0]  exp_mask [3];
    logic [9:0]  exp_addr [3];
    logic [9:0]  h_addr;
    logic [31:0] h_data;
    logic [3:0]  h_mask;
    int n_exp, bad, t, len;

    for (int i = 0; i < 256; i++) sram[i] = 8'($urandom_range(255, 1));

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("reset_ctl", ctl_outs(), 0);
    chk("reset_data", o_dramw_data, 0);
    @(posedge i_clk); #3 i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("idle_ctl", ctl_outs(), 0);

    // Aligned full vector
    start_job(8'd0, 12'd0, 9'd4, 3'd1);
    wait_done();
    chk("a_read_cnt", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("a_hiaddr", rd_q[0][5:0], 0);
    chk("a_beat_cnt", beat_q.size(), 1);
    if (beat_q.size() > 0) begin
      chk("a_addr", beat_q[0].addr, 0);
      chk("a_mask", beat_q[0].mask, 4'b1111);
      chk("a_data", beat_q[0].data, vec_of(6'd0));
    end
    check_job(8'd0, 12'd0, 4, 3'd1);

    // Misaligned on both sides
    if (MergeEn) begin
      n_exp = 2;
      exp_addr[0] = 10'd0; exp_mask[0] = 4'b1110;
      exp_addr[1] = 10'd1; exp_mask[1] = 4'b0001;
    end else begin
      n_exp = 3;
      exp_addr[0] = 10'd0; exp_mask[0] = 4'b0110;
      exp_addr[1] = 10'd0; exp_mask[1] = 4'b1000;
      exp_addr[2] = 10'd1; exp_mask[2] = 4'b0001;
    end
    start_job(8'd2, 12'd1, 9'd4, 3'd2);
    wait_done();
    chk("m_beat_cnt", beat_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < beat_q.size(); i++) begin
      chk("m_addr", beat_q[i].addr, exp_addr[i]);
      chk("m_mask", beat_q[i].mask, exp_mask[i]);
    end
    check_job(8'd2, 12'd1, 4, 3'd2);

    // Zero-length job goes straight to done
    start_job(8'd7, 12'd9, 9'd0, 3'd3);
    @(negedge i_clk);
    chk("len0_done_rdy", done_rdy, 1);
    chk("len0_no_read", sramrd_rdy, 0);
    chk("len0_done_id", o_done_id, 3);
    wait_done();
    check_job(8'd7, 12'd9, 0, 3'd3);

    // Backpressured beat must hold steady
    d_hold = 1'b1;
    start_job(8'd1, 12'd2, 9'd5, 3'd4);
    t = 0;
    while (!dramw_rdy && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    chk("hold_rdy", dramw_rdy, 1);
    h_addr = o_dramw_addr; h_data = o_dramw_data; h_mask = o_dramw_mask;
    bad = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (!dramw_rdy || o_dramw_addr !== h_addr || o_dramw_data !== h_data ||
          o_dramw_mask !== h_mask) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_mask", h_mask, MergeEn ? 4'b1100 : 4'b1100);
    chk("hold_no_beat", beat_q.size(), 0);
    d_hold = 1'b0;
    wait_done();
    check_job(8'd1, 12'd2, 5, 3'd4);

    // Reset while a read is outstanding, followed by a late return
    s_lat_min = 6; s_lat_max = 6;
    start_job(8'd4, 12'd8, 9'd6, 3'd1);
    t = 0;
    while (rd_q.size() == 0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    chk("rst_read_issued", rd_q.size(), 1);
    @(posedge i_clk); #3 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ctl", ctl_outs(), 0);
    chk("rst_data", o_dramw_data, 0);
    @(posedge i_clk); #3 i_rst = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("post_rst_ctl", ctl_outs(), 0);
    chk("post_rst_beats", beat_q.size(), 0);
    chk("post_rst_done", done_q.size(), 0);
    s_lat_min = 1; s_lat_max = 3;
    rd_q.delete();
    run_job(8'd4, 12'd8, 6, 3'd2);

    // Pointer wrap on both address spaces
    run_job(8'hFE, 12'hFFE, 6, 3'd0);

    // Random jobs
    for (int j = 0; j < 24; j++) begin
      ack_pct = $urandom_range(100, 30);
      len     = (j % 6 == 5) ? $urandom_range(40, 15) : $urandom_range(14, 0);
      run_job(8'($urandom), 12'($urandom), len, 3'($urandom_range(4, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_read_scatter.md
SRAM_READ_SCATTER -- requirements
Module: sram_read_scatter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- LBW, TauCfg::LOCAL_ADDR_BW0, local SRAM word-address width.
- GBW, TauCfg::GLOBAL_ADDR_BW, DRAM word-address width.
- DBW, TauCfg::DATA_BW, data word width.
- VSIZE, TauCfg::VECTOR_SIZE, words per SRAM vector.
- CSIZE, TauCfg::CACHE_SIZE, words per DRAM line.
- N_ICFG, TauCfg::N_ICFG, number of stream ids; ICFG_BW = $clog2(N_ICFG+1).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, the single clock.
- i_rst, in, 1, asynchronous active-low reset.
- alloc_rdy in 1 / alloc_ack out 1; i_linear in LBW; i_global in GBW; i_len in LBW+1; i_id in ICFG_BW: job request.
- sramrd_rdy out 1 / sramrd_ack in 1; o_sramrd_id out ICFG_BW; o_sramrd_hiaddr out LBW-CV_BW: vector read request.
- sramrd_dval in 1; i_sramrd_data in DBW x VSIZE: vector read return.
- dramw_rdy out 1 / dramw_ack in 1; o_dramw_addr out GBW-CC_BW; o_dramw_data out DBW x CSIZE; o_dramw_mask out CSIZE: DRAM write beat.
- done_rdy out 1 / done_ack in 1; o_done_id out ICFG_BW: job completion.

Function
REQ-003 A transfer SHALL occur on each rising edge where rdy and ack are both high; rdy SHALL NOT drop and its payload SHALL NOT change until ack.
REQ-004 The FSM SHALL be one-hot with states IDLE, RDREQ, RDWAIT, SEND and DONE.
REQ-005 IDLE SHALL assert alloc_ack combinationally when alloc_rdy is high, latch lptr=i_linear, gptr=i_global, left=i_len and id=i_id, then go to DONE if i_len==0 and to RDREQ otherwise.
REQ-006 RDREQ SHALL assert sramrd_rdy with o_sramrd_hiaddr=lptr[LBW-1:CV_BW] and o_sramrd_id=id, and go to RDWAIT on ack.
REQ-007 Exactly one SRAM read SHALL be outstanding at a time.
REQ-008 RDWAIT SHALL capture i_sramrd_data into the vector buffer on sramrd_dval, go to SEND, and ignore dval in every other state.
REQ-009 SEND SHALL compute adv=min(left, VSIZE-lptr[CV_BW-1:0], CSIZE-gptr[CC_BW-1:0]) in CV_BW1-bit arithmetic.
REQ-010 SEND beat contents SHALL be:
- data = buffer shifted right by loff*DBW, then left by goff*DBW;
- mask = (~('1<<adv))<<goff;
- o_dramw_addr = gptr[GBW-1:CC_BW];
- unmasked data lanes = 0.
REQ-011 On dramw_ack, SEND SHALL set lptr+=adv, gptr+=adv and left-=adv, then take exactly one of:
- left becomes 0: go to DONE;
- vector exhausted: go to RDREQ;
- otherwise: stay in SEND.
REQ-012 DONE SHALL assert done_rdy with o_done_id=id and go to IDLE on done_ack.
REQ-013 alloc_ack SHALL be low in every state except IDLE, so a new job is never accepted while the previous job's done is pending.
REQ-014 Pointer arithmetic SHALL wrap modulo 2^LBW (lptr) and 2^GBW (gptr) with no error signalled.

Reset
REQ-015 Reset SHALL put the FSM in IDLE and drive every rdy/ack output, o_dramw_mask, o_dramw_data, addresses and ids to 0.
REQ-016 Reset asserted mid-job SHALL abandon the job with no further beats or done, and SHALL discard any SRAM return pending at reset.

Configuration
REQ-017 With SRAM_READ_SCATTER_MERGE_EN defined, a chunk that exhausts the vector without completing the DRAM line while left>0 SHALL be OR-merged (data and mask) into a line buffer without raising dramw_rdy.
REQ-018 With SRAM_READ_SCATTER_MERGE_EN defined, a beat SHALL be emitted only when the line completes or left reaches 0.
REQ-019 With SRAM_READ_SCATTER_MERGE_EN undefined, every chunk SHALL be its own beat and no line buffer SHALL exist.

Structure
REQ-020 The FSM state enum and derived widths (CV_BW, CV_BW1, CC_BW) SHALL live in TauCfg.
REQ-021 The two-stage aligner SHALL be one combinational sub-module, sram_read_scatter_align.

Verification (bench: VSIZE=CSIZE=4, DBW=8)
REQ-022 linear=0, global=0, len=4 -> one read with hiaddr 0, one beat with addr 0, mask 1111 and data equal to the vector, then done.
REQ-023 linear=2, global=1, len=4, merge off -> beats (addr0, mask 0110), (addr0, mask 1000), (addr1, mask 0001); merge on -> beats (addr0, mask 1110), (addr1, mask 0001).
REQ-024 len=0 -> no sramrd_rdy and done_rdy high on the cycle after alloc_ack.
REQ-025 dramw_ack held low for 5 cycles in SEND -> data, mask and addr stable and no pointer advance.
REQ-026 i_rst pulsed low in RDWAIT with a late dval -> IDLE, all outputs 0, and the next job runs correctly.
